// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: collects a two-digit PIN, hands it to the lock FSM with per-nibble match
// flags, and handles entry/result timeouts and alarm lockout. PIN_PROGRAM_EN adds PIN reprogramming.
module pin_entry_ctrl #(
    parameter logic [7:0] DEFAULT_PIN    = 8'hA5,
    parameter int         ENTRY_TIMEOUT  = 500,
    parameter int         RESULT_TIMEOUT = 8,
    parameter int         LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    input  logic       lock_open,
    input  logic       deny_access,
    input  logic       alarm,
`ifdef PIN_PROGRAM_EN
    input  logic       prog_req,
    output logic       prog_done,
`endif
    output logic       req_access,
    output logic [7:0] pin,
    output logic       first_four_match,
    output logic       last_four_match,
    output logic       busy,
    output logic       lockout,
    output logic       entry_timeout
);

    localparam int MAX_AB = (ENTRY_TIMEOUT > RESULT_TIMEOUT) ? ENTRY_TIMEOUT : RESULT_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > LOCKOUT_CYCLES) ? MAX_AB : LOCKOUT_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] ENTRY_LAST  = CW'(ENTRY_TIMEOUT - 1);
    localparam logic [CW-1:0] RESULT_LAST = CW'(RESULT_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HAVE_HI   = 3'd1,
        S_REQ       = 3'd2,
        S_WAIT_RES  = 3'd3,
        S_DENY_HOLD = 3'd4,
        S_LOCKOUT   = 3'd5,
        S_PROG_HI   = 3'd6,
        S_PROG_LO   = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [7:0]    pin_q, pin_d;
    logic          req_access_q, req_access_d;
    logic          first_four_match_q, first_four_match_d;
    logic          last_four_match_q, last_four_match_d;
    logic          busy_q, busy_d;
    logic          lockout_q, lockout_d;
    logic          entry_timeout_q, entry_timeout_d;
    logic          match_win_s;
    logic [7:0]    stored_pin_s;

`ifdef PIN_PROGRAM_EN
    logic [7:0] stored_q, stored_d;
    logic [3:0] prog_hi_q, prog_hi_d;
    logic       prog_done_q, prog_done_d;
    assign stored_pin_s = stored_q;
    assign prog_done    = prog_done_q;
`else
    assign stored_pin_s = DEFAULT_PIN;
`endif

    assign req_access       = req_access_q;
    assign pin              = pin_q;
    assign first_four_match = first_four_match_q;
    assign last_four_match  = last_four_match_q;
    assign busy             = busy_q;
    assign lockout          = lockout_q;
    assign entry_timeout    = entry_timeout_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CW'(1);
        end
    endfunction

    // Next-state, datapath and registered-output precompute.
    always_comb begin
        state_d         = state_q;
        pin_d           = pin_q;
        timer_d         = sat_inc(timer_q);
        entry_timeout_d = 1'b0;
`ifdef PIN_PROGRAM_EN
        stored_d    = stored_q;
        prog_hi_d   = prog_hi_q;
        prog_done_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = CNT_ZERO;
                if (alarm) begin
                    state_d = S_LOCKOUT;
                end
`ifdef PIN_PROGRAM_EN
                else if (prog_req && lock_open) begin
                    state_d = S_PROG_HI;
                end
`endif
                else if (key_valid) begin
                    pin_d   = {key_digit, 4'h0};
                    state_d = S_HAVE_HI;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HAVE_HI: begin
                if (alarm) begin
                    state_d = S_LOCKOUT;
                    timer_d = CNT_ZERO;
                    pin_d   = 8'h00;
                end else if (key_clear) begin
                    state_d = S_IDLE;
                    pin_d   = 8'h00;
                end else if (key_valid) begin
                    pin_d   = {pin_q[7:4], key_digit};
                    state_d = S_REQ;
                end else if (timer_q >= ENTRY_LAST) begin
                    entry_timeout_d = 1'b1;
                    state_d         = S_IDLE;
                    pin_d           = 8'h00;
                end else begin
                    state_d = S_HAVE_HI;
                end
            end
            S_REQ: begin
                timer_d = CNT_ZERO;
                if (key_clear) begin
                    state_d = S_IDLE;
                    pin_d   = 8'h00;
                end else begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (lock_open) begin
                    state_d = S_IDLE;
                    pin_d   = 8'h00;
                end else if (deny_access) begin
                    state_d = S_DENY_HOLD;
                    timer_d = CNT_ZERO;
                end else if (timer_q >= RESULT_LAST) begin
                    entry_timeout_d = 1'b1;
                    state_d         = S_IDLE;
                    pin_d           = 8'h00;
                end else begin
                    state_d = S_WAIT_RES;
                end
            end
            S_DENY_HOLD: begin
                // Held two cycles so the lock's alarm following a deny is caught here.
                if (alarm) begin
                    state_d = S_LOCKOUT;
                    timer_d = CNT_ZERO;
                    pin_d   = 8'h00;
                end else if (timer_q >= HOLD_LAST) begin
                    state_d = S_IDLE;
                    pin_d   = 8'h00;
                end else begin
                    state_d = S_DENY_HOLD;
                end
            end
            S_LOCKOUT: begin
                if (alarm) begin
                    timer_d = CNT_ZERO;
                end else if (timer_q >= LOCK_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOCKOUT;
                end
            end
`ifdef PIN_PROGRAM_EN
            S_PROG_HI: begin
                if (alarm) begin
                    state_d = S_LOCKOUT;
                    timer_d = CNT_ZERO;
                end else if (key_clear) begin
                    state_d = S_IDLE;
                end else if (key_valid) begin
                    prog_hi_d = key_digit;
                    state_d   = S_PROG_LO;
                    timer_d   = CNT_ZERO;
                end else if (timer_q >= ENTRY_LAST) begin
                    entry_timeout_d = 1'b1;
                    state_d         = S_IDLE;
                end else begin
                    state_d = S_PROG_HI;
                end
            end
            S_PROG_LO: begin
                if (alarm) begin
                    state_d = S_LOCKOUT;
                    timer_d = CNT_ZERO;
                end else if (key_clear) begin
                    state_d = S_IDLE;
                end else if (key_valid) begin
                    stored_d    = {prog_hi_q, key_digit};
                    prog_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (timer_q >= ENTRY_LAST) begin
                    entry_timeout_d = 1'b1;
                    state_d         = S_IDLE;
                end else begin
                    state_d = S_PROG_LO;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                pin_d   = 8'h00;
                timer_d = CNT_ZERO;
            end
        endcase

        // Flags only mean something while the lock is looking at the PIN.
        match_win_s        = (state_d == S_REQ) || (state_d == S_WAIT_RES) ||
                             (state_d == S_DENY_HOLD);
        req_access_d       = (state_d == S_REQ);
        busy_d             = (state_d != S_IDLE);
        lockout_d          = (state_d == S_LOCKOUT);
        first_four_match_d = match_win_s && (pin_d[7:4] == stored_pin_s[7:4]);
        last_four_match_d  = match_win_s && (pin_d[3:0] == stored_pin_s[3:0]);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            timer_q            <= CNT_ZERO;
            pin_q              <= 8'h00;
            req_access_q       <= 1'b0;
            first_four_match_q <= 1'b0;
            last_four_match_q  <= 1'b0;
            busy_q             <= 1'b0;
            lockout_q          <= 1'b0;
            entry_timeout_q    <= 1'b0;
`ifdef PIN_PROGRAM_EN
            stored_q    <= DEFAULT_PIN;
            prog_hi_q   <= 4'h0;
            prog_done_q <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            timer_q            <= timer_d;
            pin_q              <= pin_d;
            req_access_q       <= req_access_d;
            first_four_match_q <= first_four_match_d;
            last_four_match_q  <= last_four_match_d;
            busy_q             <= busy_d;
            lockout_q          <= lockout_d;
            entry_timeout_q    <= entry_timeout_d;
`ifdef PIN_PROGRAM_EN
            stored_q    <= stored_d;
            prog_hi_q   <= prog_hi_d;
            prog_done_q <= prog_done_d;
`endif
        end
    end

endmodule
